// File: rtl/sram_resp_if.sv
// Request/response bus between an initiator (master) and sram_resp (slave).
// The initiator holds en and all request fields stable while stall is high.
interface sram_resp_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        addr_err;

    modport master (
        output en, wen, addr, wdata,
        input  rdata, stall, addr_err
    );

    modport slave (
        input  en, wen, addr, wdata,
        output rdata, stall, addr_err
    );
endinterface

// File: rtl/sram_resp.sv
// Word SRAM with byte-lane writes; each request stalls for WAIT_CYCLES+1 cycles, response in DONE.
// Optional address checking is enabled by defining SRAM_RESP_ADDR_CHK_EN.
module sram_resp #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    sram_resp_if.slave  bus
);
    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [3:0]            wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  err_q, err_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  addr_err_q, addr_err_d;

    logic [31:0]           mem [DEPTH];

    logic [ADDR_WIDTH-1:0] in_idx;
    logic                  in_err;
    logic                  stall;
    logic                  commit;
    logic                  mem_we;
    logic [3:0]            c_wen;
    logic [ADDR_WIDTH-1:0] c_idx;
    logic                  c_err;
    logic [31:0]           c_wdata;

    assign in_idx = bus.addr[ADDR_WIDTH+1:2];

`ifdef SRAM_RESP_ADDR_CHK_EN
    assign in_err = (bus.addr[1:0] != 2'b00) || (bus.addr[31:ADDR_WIDTH+2] != '0);
`else
    // Without checking, the extra address bits alias onto the word index.
    logic unused_addr_bits;
    assign in_err           = 1'b0;
    assign unused_addr_bits = ^{bus.addr[31:ADDR_WIDTH+2], bus.addr[1:0]};
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wen_d      = wen_q;
        idx_d      = idx_q;
        err_d      = err_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        addr_err_d = 1'b0;
        stall      = 1'b0;
        commit     = 1'b0;
        c_wen      = wen_q;
        c_idx      = idx_q;
        c_err      = err_q;
        c_wdata    = wdata_q;

        unique case (state_q)
            IDLE: begin
                stall = bus.en;
                if (bus.en) begin
                    wen_d   = bus.wen;
                    idx_d   = in_idx;
                    err_d   = in_err;
                    wdata_d = bus.wdata;
                    cnt_d   = CNT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        // Zero-wait: the request commits straight from the bus fields.
                        state_d = DONE;
                        commit  = 1'b1;
                        c_wen   = bus.wen;
                        c_idx   = in_idx;
                        c_err   = in_err;
                        c_wdata = bus.wdata;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    commit  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (commit) begin
            addr_err_d = c_err;
            if (c_err) begin
                rdata_d = '0;
            end else if (c_wen == 4'b0000) begin
                rdata_d = mem[c_idx];
            end
        end
    end

    assign mem_we = commit && !c_err && (c_wen != 4'b0000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wen_q      <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wen_q      <= wen_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Storage is never reset; a write in flight when reset hits is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (c_wen[i]) begin
                    mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.stall    = stall;
    assign bus.addr_err = addr_err_q;
endmodule

// File: tb/tb_sram_resp.sv
// Bench for sram_resp: one instance with WAIT_CYCLES=2, one with WAIT_CYCLES=0,
// checked every cycle against a transaction-level model plus literal expectations.
module tb_sram_resp;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    logic        en_a   [2];
    logic [3:0]  wen_a  [2];
    logic [31:0] addr_a [2];
    logic [31:0] wd_a   [2];
    logic [31:0] rd_a   [2];
    logic        st_a   [2];
    logic        er_a   [2];
    int          last_done [2];

    sram_resp_if bus0 ();
    sram_resp_if bus1 ();

    assign bus0.en = en_a[0];  assign bus0.wen = wen_a[0];
    assign bus0.addr = addr_a[0]; assign bus0.wdata = wd_a[0];
    assign rd_a[0] = bus0.rdata; assign st_a[0] = bus0.stall; assign er_a[0] = bus0.addr_err;
    assign bus1.en = en_a[1];  assign bus1.wen = wen_a[1];
    assign bus1.addr = addr_a[1]; assign bus1.wdata = wd_a[1];
    assign rd_a[1] = bus1.rdata; assign st_a[1] = bus1.stall; assign er_a[1] = bus1.addr_err;

    sram_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    sram_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h want %h", nm, i, got, exp);
        end
    endtask

    // Transaction-level model: cycles remaining until the response, and the pending request.
    int          resp   [2];
    logic [31:0] ex_rd  [2];
    logic [3:0]  p_wen  [2];
    logic [9:0]  p_idx  [2];
    logic [31:0] p_wd   [2];
    bit          p_err  [2];
    logic [31:0] mm     [2][1024];

    function automatic int wait_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic bit bad_addr(input logic [31:0] a);
`ifdef SRAM_RESP_ADDR_CHK_EN
        return (a[1:0] != 2'b00) || (a[31:12] != 20'h0);
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        logic es, ee;
        for (int i = 0; i < 2; i++) begin
            ee = 1'b0;
            if (rst) begin
                resp[i]  = -1;
                ex_rd[i] = 32'h0;
                es       = en_a[i];
            end else if (resp[i] == 0) begin
                es = 1'b0;
                ee = p_err[i];
                if (p_err[i]) ex_rd[i] = 32'h0;
                else if (p_wen[i] == 4'h0) ex_rd[i] = mm[i][p_idx[i]];
                else for (int b = 0; b < 4; b++)
                    if (p_wen[i][b]) mm[i][p_idx[i]][8*b +: 8] = p_wd[i][8*b +: 8];
                resp[i] = -1;
            end else if (resp[i] > 0) begin
                es = 1'b1;
                resp[i]--;
            end else begin
                es = en_a[i];
                if (en_a[i]) begin
                    p_wen[i] = wen_a[i];
                    p_idx[i] = addr_a[i][11:2];
                    p_wd[i]  = wd_a[i];
                    p_err[i] = bad_addr(addr_a[i]);
                    resp[i]  = wait_of(i);
                end
            end
            chk("stall", i, 32'(st_a[i]), 32'(es));
            chk("rdata", i, rd_a[i], ex_rd[i]);
            chk("addr_err", i, 32'(er_a[i]), 32'(ee));
        end
    end

    task automatic do_req(input int i, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                          input bit scr, input bit chk_rd, input logic [31:0] lit_rd,
                          input int lit_err, input int lit_st);
        int n = 0;
        bit done = 1'b0;
        @(posedge clk); #1;
        en_a[i] = 1'b1; wen_a[i] = w; addr_a[i] = a; wd_a[i] = d;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (st_a[i]) begin
                n++;
                @(posedge clk); #1;
                if (scr) begin
                    addr_a[i] = 32'h44; wd_a[i] = 32'h0BADF00D; wen_a[i] = 4'h0;
                end
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout[%0d] addr %h no response within 40 cycles", i, a);
        end else begin
            last_done[i] = cyc_cnt;
            chk("stall_len", i, 32'(n), 32'(lit_st));
            if (chk_rd) chk($sformatf("rd_lit@%h", a), i, rd_a[i], lit_rd);
            if (lit_err >= 0) chk("err_lit", i, 32'(er_a[i]), 32'(lit_err));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        int gap;
        for (int i = 0; i < 2; i++) begin
            en_a[i] = 1'b0; wen_a[i] = 4'h0; addr_a[i] = 32'h0; wd_a[i] = 32'h0;
            resp[i] = -1; ex_rd[i] = 32'h0; last_done[i] = 0;
        end
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", 0, 32'(st_a[0]), 32'h0);
        chk("rst_rdata", 0, rd_a[0], 32'h0);
        chk("rst_err", 0, 32'(er_a[0]), 32'h0);

        // WAIT_CYCLES=2 instance
        do_req(0, 4'hF, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 0, 3);
        do_req(0, 4'h0, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF, 0, 3);
        do_req(0, 4'hF, 32'h20, 32'h11223344, 0, 0, 32'h0, 0, 3);
        do_req(0, 4'b0101, 32'h20, 32'hAABBCCDD, 0, 1, 32'hDEADBEEF, 0, 3);
        do_req(0, 4'h0, 32'h20, 32'h0, 0, 1, 32'h11BB33DD, 0, 3);

        // Reset during BUSY of a write aborts it
        do_req(0, 4'hF, 32'h30, 32'h0, 0, 0, 32'h0, 0, 3);
        @(posedge clk); #1;
        en_a[0] = 1'b1; wen_a[0] = 4'hF; addr_a[0] = 32'h30; wd_a[0] = 32'hCAFEF00D;
        @(negedge clk);
        @(posedge clk); #2;
        en_a[0] = 1'b0; rst = 1'b1;
        #1;
        chk("midrst_stall", 0, 32'(st_a[0]), 32'h0);
        chk("midrst_rdata", 0, rd_a[0], 32'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        do_req(0, 4'h0, 32'h30, 32'h0, 0, 1, 32'h0, 0, 3);

        // Fields changing while stalled are ignored
        do_req(0, 4'hF, 32'h44, 32'h55555555, 0, 0, 32'h0, 0, 3);
        do_req(0, 4'hF, 32'h40, 32'h12345678, 1, 0, 32'h0, 0, 3);
        do_req(0, 4'h0, 32'h40, 32'h0, 1, 1, 32'h12345678, 0, 3);
        do_req(0, 4'h0, 32'h44, 32'h0, 0, 1, 32'h55555555, 0, 3);

        // Out-of-range address: checked or aliased onto index 0
        do_req(0, 4'hF, 32'h0, 32'h01020304, 0, 0, 32'h0, 0, 3);
`ifdef SRAM_RESP_ADDR_CHK_EN
        do_req(0, 4'hF, 32'h1002, 32'h99887766, 0, 1, 32'h0, 1, 3);
        do_req(0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h01020304, 0, 3);
`else
        do_req(0, 4'hF, 32'h1002, 32'h99887766, 0, 1, 32'h55555555, 0, 3);
        do_req(0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h99887766, 0, 3);
`endif
        @(posedge clk); #1 en_a[0] = 1'b0;

        // WAIT_CYCLES=0 instance: back-to-back with no idle gap
        do_req(1, 4'hF, 32'h0, 32'hA5A5A5A5, 0, 0, 32'h0, 0, 1);
        do_req(1, 4'hF, 32'h4, 32'h5A5A5A5A, 0, 0, 32'h0, 0, 1);
        do_req(1, 4'h0, 32'h0, 32'h0, 0, 1, 32'hA5A5A5A5, 0, 1);
        gap = last_done[1];
        do_req(1, 4'h0, 32'h4, 32'h0, 0, 1, 32'h5A5A5A5A, 0, 1);
        chk("done_gap", 1, 32'(last_done[1] - gap), 32'd2);
        @(posedge clk); #1 en_a[1] = 1'b0;

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
